// File: rtl/gate_check_pkg.sv
// rtl/gate_check_pkg.sv - shared types and constants for the gate truth-table checker
package gate_check_pkg;

  // Width of the settle counter; supports SETTLE values 0..15.
  localparam int SETTLE_W = 4;

  typedef enum logic [2:0] {
    IDLE,
    APPLY,
    WAIT,
    SAMPLE,
    FINISH
  } state_t;

  // Number of input combinations for a gate with n_in inputs.
  function automatic int num_vec(input int n_in);
    return 1 << n_in;
  endfunction

endpackage

// File: rtl/gate_settle_timer.sv
// rtl/gate_settle_timer.sv - loadable down-counter timing the settle wait
module gate_settle_timer
  import gate_check_pkg::*;
#(
  parameter int W = SETTLE_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_value,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         zero
);

  localparam logic [W-1:0] ONE = 1;

  // Load has priority; decrement saturates at zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (dec && !zero) begin
      count <= count - ONE;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/gate_truth_checker.sv
// rtl/gate_truth_checker.sv - walks all gate inputs and checks outputs against a truth table (option: GATE_CHECK_STOP_ON_FAIL_EN)
module gate_truth_checker
  import gate_check_pkg::*;
#(
  parameter int N_IN   = 2,
  parameter int SETTLE = 1,
  localparam int NUM_VEC = num_vec(N_IN)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [NUM_VEC-1:0] expected,
  input  logic               dut_out,
  output logic [N_IN-1:0]    stim,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [N_IN:0]      err_count,
  output logic [N_IN-1:0]    first_fail,
  output logic               fail_valid
);

  localparam logic [SETTLE_W-1:0] SETTLE_VAL = SETTLE_W'(SETTLE);
  localparam logic [SETTLE_W-1:0] TIMER_ONE  = 1;
  localparam logic [N_IN-1:0]     STIM_ONE   = 1;
  localparam logic [N_IN-1:0]     STIM_LAST  = '1;
  localparam logic [N_IN:0]       ERR_ONE    = 1;

  state_t state, state_next;

  logic [NUM_VEC-1:0]  exp_q;
  logic                run_load;
  logic                timer_load;
  logic                timer_dec;
  logic                sample_en;
  logic                finish_en;
  logic [SETTLE_W-1:0] timer_count;
  logic                timer_zero;
  logic                mismatch;
  logic                last_vec;
  logic                stop_run;

  gate_settle_timer #(.W(SETTLE_W)) u_timer (
    .clk        (clk),
    .reset      (reset),
    .load       (timer_load),
    .load_value (SETTLE_VAL),
    .dec        (timer_dec),
    .count      (timer_count),
    .zero       (timer_zero)
  );

  assign mismatch = (dut_out != exp_q[stim]);
  assign last_vec = (stim == STIM_LAST);

`ifdef GATE_CHECK_STOP_ON_FAIL_EN
  assign stop_run = mismatch || last_vec;
`else
  assign stop_run = last_vec;
`endif

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode and per-state control strobes for the datapath.
  always_comb begin
    state_next = state;
    run_load   = 1'b0;
    timer_load = 1'b0;
    timer_dec  = 1'b0;
    sample_en  = 1'b0;
    finish_en  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          run_load   = 1'b1;
          state_next = APPLY;
        end
      end
      APPLY: begin
        timer_load = 1'b1;
        state_next = (SETTLE > 0) ? WAIT : SAMPLE;
      end
      WAIT: begin
        timer_dec = 1'b1;
        if (timer_zero || timer_count == TIMER_ONE) begin
          state_next = SAMPLE;
        end
      end
      SAMPLE: begin
        sample_en  = 1'b1;
        state_next = stop_run ? FINISH : APPLY;
      end
      FINISH: begin
        finish_en  = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Run bookkeeping: latch table, step stimulus, count mismatches, publish result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      exp_q      <= '0;
      stim       <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_count  <= '0;
      first_fail <= '0;
      fail_valid <= 1'b0;
    end else begin
      done <= 1'b0;
      if (run_load) begin
        exp_q      <= expected;
        err_count  <= '0;
        fail_valid <= 1'b0;
        first_fail <= '0;
        pass       <= 1'b0;
        stim       <= '0;
        busy       <= 1'b1;
      end
      if (sample_en) begin
        if (mismatch) begin
          err_count <= err_count + ERR_ONE;
          if (!fail_valid) begin
            fail_valid <= 1'b1;
            first_fail <= stim;
          end
        end
        // Terminal check comes first so stim never wraps past the last vector.
        if (!stop_run) begin
          stim <= stim + STIM_ONE;
        end
      end
      if (finish_en) begin
        done <= 1'b1;
        pass <= (err_count == '0);
        busy <= 1'b0;
        stim <= '0;
      end
    end
  end

endmodule

// File: tb/tb_gate_truth_checker.sv
// tb/tb_gate_truth_checker.sv - directed-vector bench for gate_truth_checker
module tb_gate_truth_checker;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [3:0] expected;
  logic       dut_out;
  logic [1:0] stim;
  logic       busy;
  logic       done;
  logic       pass;
  logic [2:0] err_count;
  logic [1:0] first_fail;
  logic       fail_valid;

  int mode;
  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  gate_truth_checker #(.N_IN(2), .SETTLE(1)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .expected   (expected),
    .dut_out    (dut_out),
    .stim       (stim),
    .busy       (busy),
    .done       (done),
    .pass       (pass),
    .err_count  (err_count),
    .first_fail (first_fail),
    .fail_valid (fail_valid)
  );

  // Gate under test: OR from three NANDs (mode 0), stuck-at-0 (mode 1), NOR (mode 2).
  logic na, nb, or_nand;
  assign na      = ~(stim[1] & stim[1]);
  assign nb      = ~(stim[0] & stim[0]);
  assign or_nand = ~(na & nb);
  assign dut_out = (mode == 0) ? or_nand : (mode == 1) ? 1'b0 : ~or_nand;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic run_and_check(input string name, input logic [3:0] table_in, input int gate,
                               input int exp_cycles, input int exp_err, input int exp_ff,
                               input bit poke);
    int cyc;
    mode     = gate;
    expected = table_in;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    cyc   = 0;
    check_eq({name, " busy"}, busy, 1);
    while (!done && cyc < 100) begin
      if (cyc % 3 == 0 && cyc < exp_cycles - 1) begin
        check_eq({name, " stim"}, stim, cyc / 3);
      end
      if (poke && cyc == 4) begin
        start    = 1'b1;
        expected = ~table_in;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    start    = 1'b0;
    expected = table_in;
    check_eq({name, " done_cycle"}, cyc, exp_cycles);
    check_eq({name, " done"}, done, 1);
    check_eq({name, " busy_end"}, busy, 0);
    check_eq({name, " stim_end"}, stim, 0);
    check_eq({name, " err_count"}, err_count, exp_err);
    check_eq({name, " fail_valid"}, fail_valid, (exp_err > 0) ? 1 : 0);
    check_eq({name, " first_fail"}, first_fail, exp_ff);
    check_eq({name, " pass"}, pass, (exp_err == 0) ? 1 : 0);
  endtask

  initial begin
    int seen;
    reset    = 1'b1;
    start    = 1'b0;
    mode     = 0;
    expected = 4'b1110;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst busy", busy, 0);
    check_eq("rst done", done, 0);
    check_eq("rst pass", pass, 0);
    check_eq("rst err_count", err_count, 0);
    check_eq("rst first_fail", first_fail, 0);
    check_eq("rst fail_valid", fail_valid, 0);
    check_eq("rst stim", stim, 0);
    @(negedge clk);
    reset = 1'b0;

    run_and_check("or_good", 4'b1110, 0, 13, 0, 0, 1'b0);
    @(posedge clk);
    #1;
    check_eq("done_one_cycle", done, 0);
    check_eq("pass_held", pass, 1);

`ifdef GATE_CHECK_STOP_ON_FAIL_EN
    run_and_check("stuck0", 4'b1110, 1, 7, 1, 1, 1'b0);
    run_and_check("nor", 4'b1110, 2, 4, 1, 0, 1'b0);
`else
    run_and_check("stuck0", 4'b1110, 1, 13, 3, 1, 1'b0);
    run_and_check("nor", 4'b1110, 2, 13, 4, 0, 1'b0);
`endif

    // Reset in the WAIT state of vector 10.
`ifdef GATE_CHECK_STOP_ON_FAIL_EN
    mode = 0;
`else
    mode = 1;
`endif
    expected = 4'b1110;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    check_eq("pre_reset stim", stim, 2);
    check_eq("pre_reset busy", busy, 1);
    #2;
    reset = 1'b1;
    #1;
    check_eq("async_rst busy", busy, 0);
    check_eq("async_rst stim", stim, 0);
    check_eq("async_rst err_count", err_count, 0);
    check_eq("async_rst fail_valid", fail_valid, 0);
    check_eq("async_rst first_fail", first_fail, 0);
    check_eq("async_rst pass", pass, 0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    seen  = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (done) seen = 1;
    end
    check_eq("no_done_after_reset", seen, 0);

    run_and_check("after_reset", 4'b1110, 0, 13, 0, 0, 1'b1);
    run_and_check("back_to_back_nor", 4'b0001, 2, 13, 0, 0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
